// File: rtl/cn_pkg.sv
// Shared types and sizing for the min-sum check-node output stage.
// Optional macro OFFSET_MS_EN (used by cn_msg_expander) enables offset min-sum.
package cn_pkg;
  localparam int W      = 6;
  localparam int Wc     = 4;
  localparam int OFFSET = 1;
  localparam int IDXW   = $clog2(Wc);
  localparam int MW     = W - 1;

  typedef struct packed {
    logic [MW-1:0]   min1;
    logic [MW-1:0]   min2;
    logic [IDXW-1:0] idx;
    logic [Wc-1:0]   sign;
  } cn_rec_t;

  typedef struct packed {
    logic          sign;
    logic [MW-1:0] mag;
  } c2v_msg_t;
endpackage

// File: rtl/cn_rec_fifo.sv
// Two-entry record FIFO; exposes the head and the entry behind it.
module cn_rec_fifo
  import cn_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_push,
  input  logic       i_pop,
  input  cn_rec_t    i_rec,
  output cn_rec_t    o_head,
  output cn_rec_t    o_next,
  output logic [1:0] o_count
);
  cn_rec_t    r_mem [2];
  logic       r_wptr;
  logic       r_rptr;
  logic [1:0] r_count;

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr] <= i_rec;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (i_push) r_wptr <= ~r_wptr;
      if (i_pop)  r_rptr <= ~r_rptr;
      r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
    end
  end

  assign o_head  = r_mem[r_rptr];
  assign o_next  = r_mem[~r_rptr];
  assign o_count = r_count;
endmodule

// File: rtl/cn_msg_expander.sv
// Expands buffered check-node records into Wc serial check-to-variable messages.
// OFFSET_MS_EN: subtract OFFSET from every magnitude, saturating at zero.
module cn_msg_expander
  import cn_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-2:0]    in_min1,
  input  logic [W-2:0]    in_min2,
  input  logic [IDXW-1:0] in_idx,
  input  logic [Wc-1:0]   in_sign,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_msg,
  output logic [IDXW-1:0] out_edge,
  output logic            out_last
);
  typedef enum logic {IDLE, EMIT} state_t;

  state_t          r_state;
  logic            r_ready;
  logic            r_valid;
  c2v_msg_t        r_msg;
  logic [IDXW-1:0] r_edge;
  logic            r_last;

  cn_rec_t         w_in_rec;
  cn_rec_t         w_head;
  cn_rec_t         w_next;
  cn_rec_t         w_nxt_rec;
  logic [1:0]      w_count;
  logic [1:0]      w_cnt_nxt;
  logic            w_push;
  logic            w_pop;
  logic            w_nxt_avail;
  logic [IDXW-1:0] w_edge_inc;

  function automatic c2v_msg_t expand(cn_rec_t r, logic [IDXW-1:0] k);
    c2v_msg_t m;
    m.sign = (^r.sign) ^ r.sign[k];
    m.mag  = (k == r.idx) ? r.min2 : r.min1;
`ifdef OFFSET_MS_EN
    m.mag  = (m.mag > MW'(OFFSET)) ? m.mag - MW'(OFFSET) : '0;
`endif
    return m;
  endfunction

  assign w_in_rec = '{min1: in_min1, min2: in_min2, idx: in_idx, sign: in_sign};
  assign w_push   = in_valid && r_ready;
  assign w_pop    = (r_state == EMIT) && out_ready && (r_edge == IDXW'(Wc - 1));

  cn_rec_fifo u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_rec   (w_in_rec),
    .o_head  (w_head),
    .o_next  (w_next),
    .o_count (w_count)
  );

  assign w_cnt_nxt   = w_count + {1'b0, w_push} - {1'b0, w_pop};
  // After a pop the follow-on record is either the second buffered entry or
  // the one arriving this cycle, which lets records stream without a bubble.
  assign w_nxt_rec   = (w_count == 2'd2) ? w_next : w_in_rec;
  assign w_nxt_avail = (w_count == 2'd2) || w_push;
  assign w_edge_inc  = r_edge + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ready <= 1'b0;
      r_valid <= 1'b0;
      r_msg   <= '0;
      r_edge  <= '0;
      r_last  <= 1'b0;
    end else begin
      r_ready <= (w_cnt_nxt < 2'd2);
      case (r_state)
        IDLE: begin
          // FIFO is empty here, so the arriving record is the head.
          if (w_push) begin
            r_msg   <= expand(w_in_rec, '0);
            r_edge  <= '0;
            r_last  <= 1'b0;
            r_valid <= 1'b1;
            r_state <= EMIT;
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (!r_last) begin
              r_msg  <= expand(w_head, w_edge_inc);
              r_edge <= w_edge_inc;
              r_last <= (w_edge_inc == IDXW'(Wc - 1));
            end else if (w_nxt_avail) begin
              r_msg  <= expand(w_nxt_rec, '0);
              r_edge <= '0;
              r_last <= 1'b0;
            end else begin
              r_edge  <= '0;
              r_last  <= 1'b0;
              r_valid <= 1'b0;
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = r_ready;
  assign out_valid = r_valid;
  assign out_msg   = r_msg;
  assign out_edge  = r_edge;
  assign out_last  = r_last;
endmodule

// File: tb/tb_cn_msg_expander.sv
// Directed bench for cn_msg_expander: queue-based message model plus literal pins.
module tb_cn_msg_expander;
  import cn_pkg::*;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [MW-1:0]   in_min1 = '0;
  logic [MW-1:0]   in_min2 = '0;
  logic [IDXW-1:0] in_idx = '0;
  logic [Wc-1:0]   in_sign = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [W-1:0]    out_msg;
  logic [IDXW-1:0] out_edge;
  logic            out_last;

  cn_msg_expander dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_min1(in_min1), .in_min2(in_min2), .in_idx(in_idx), .in_sign(in_sign),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_msg(out_msg), .out_edge(out_edge), .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] msg;
    int           eidx;
  } exp_t;

  exp_t expq[$];
  int   n_chk = 0;
  int   n_fail = 0;

  // Spec-level message: sign = parity of all signs except own edge; magnitude
  // is min2 on the min1 edge, min1 elsewhere.
  function automatic logic [W-1:0] model(int m1, int m2, int idx, logic [Wc-1:0] s, int k);
    int   mag;
    logic sg;
    sg = 1'b0;
    for (int j = 0; j < Wc; j++) if (j != k) sg = sg ^ s[j];
    mag = (k == idx) ? m2 : m1;
`ifdef OFFSET_MS_EN
    mag = (mag > OFFSET) ? mag - OFFSET : 0;
`endif
    return {sg, MW'(mag)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Single compare process: outputs must track the model queue every cycle.
  always @(negedge clk) begin
    if (rst) begin
      expq.delete();
    end else begin
      chk("out_valid", {31'd0, out_valid}, {31'd0, expq.size() != 0});
      if (out_valid && expq.size() != 0) begin
        chk("out_msg", {26'd0, out_msg}, {26'd0, expq[0].msg});
        chk("out_edge", 32'(out_edge), 32'(expq[0].eidx));
        chk("out_last", {31'd0, out_last}, {31'd0, expq[0].eidx == Wc - 1});
      end
      if (out_valid && out_ready && expq.size() != 0) void'(expq.pop_front());
      if (in_valid && in_ready)
        for (int k = 0; k < Wc; k++)
          expq.push_back('{msg: model(int'(in_min1), int'(in_min2), int'(in_idx), in_sign, k), eidx: k});
    end
  end

  task automatic send(input int m1, input int m2, input int idx, input logic [Wc-1:0] s);
    int t;
    t = 0;
    in_min1 = MW'(m1); in_min2 = MW'(m2); in_idx = IDXW'(idx); in_sign = s;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && t < 200) begin t++; @(negedge clk); end
    if (!in_ready) chk("send_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (expq.size() != 0 && t < 200) begin @(posedge clk); t++; end
    #1;
    chk("drain_valid", {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int acc_at;
    int t;
    // Model pins (hand-computed)
    chk("pin_basic0", model(3, 7, 2, 4'b0110, 0), 32'h03);
    chk("pin_basic1", model(3, 7, 2, 4'b0110, 1), 32'h23);
    chk("pin_basic2", model(3, 7, 2, 4'b0110, 2), 32'h27);
    chk("pin_basic3", model(3, 7, 2, 4'b0110, 3), 32'h03);
    chk("pin_odd0", model(2, 5, 0, 4'b0001, 0), 32'h05);
    chk("pin_odd1", model(2, 5, 0, 4'b0001, 1), 32'h22);
    chk("pin_tie3", model(6, 6, 3, 4'b0000, 3), 32'h06);
`ifdef OFFSET_MS_EN
    chk("pin_offs0", model(0, 4, 1, 4'b0000, 0), 32'h00);
    chk("pin_offs1", model(0, 4, 1, 4'b0000, 1), 32'h03);
`else
    chk("pin_plain1", model(0, 4, 1, 4'b0000, 1), 32'h04);
`endif

    // Reset state
    repeat (2) @(posedge clk); #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_msg", {26'd0, out_msg}, 32'd0);
    chk("rst_out_edge", 32'(out_edge), 32'd0);
    chk("rst_out_last", {31'd0, out_last}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_ready", {31'd0, in_ready}, 32'd1);

    // Basic expansion with one-cycle latency
    out_ready = 1'b1;
    send(3, 7, 2, 4'b0110);
    chk("lat_valid", {31'd0, out_valid}, 32'd1);
    chk("lat_msg", {26'd0, out_msg}, {26'd0, model(3, 7, 2, 4'b0110, 0)});
    drain();
    send(2, 5, 0, 4'b0001);  drain();  // odd parity
    send(6, 6, 3, 4'b1010);  drain();  // tie
    send(0, 4, 1, 4'b0000);  drain();  // offset/underflow vector
    send(31, 0, 3, 4'b1111); send(1, 2, 1, 4'b1000); drain();  // back-to-back

    // Backpressure: two records buffer, third waits for first out_last
    out_ready = 1'b0;
    send(3, 7, 2, 4'b0110);
    send(2, 5, 0, 4'b0001);
    chk("bp_full", {31'd0, in_ready}, 32'd0);
    in_min1 = 5'd6; in_min2 = 5'd6; in_idx = 2'd3; in_sign = 4'b1010;
    in_valid = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chk("bp_hold_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_hold_msg", {26'd0, out_msg}, {26'd0, model(3, 7, 2, 4'b0110, 0)});
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    acc_at = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("bp_no_bubble", {31'd0, out_valid}, 32'd1);
      if (in_valid && in_ready && acc_at < 0) acc_at = i;
      @(posedge clk); #1;
      if (acc_at >= 0) in_valid = 1'b0;
    end
    chk("bp_accept_cycle", 32'(acc_at), 32'd4);
    drain();

    // Reset mid-record with a second record buffered
    send(5, 9, 1, 4'b1100);
    send(1, 2, 3, 4'b0011);
    t = 0;
    while (out_edge != 2'd1 && t < 20) begin @(posedge clk); #1; t++; end
    chk("mid_edge1", 32'(out_edge), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_ready", {31'd0, in_ready}, 32'd0);
    chk("mid_rst_edge", 32'(out_edge), 32'd0);
    @(posedge clk); #1;
    chk("mid_post_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_post_valid", {31'd0, out_valid}, 32'd0);
    send(4, 4, 0, 4'b1111);
    chk("restart_edge", 32'(out_edge), 32'd0);
    chk("restart_valid", {31'd0, out_valid}, 32'd1);
    drain();

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
